// File: rtl/exc_pkg.sv
// Shared types and constants for the exception controller.
// Holds the controller state enum, cause-code constants, default
// parameter values and the index-to-cause helper.
package exc_pkg;

  localparam int unsigned NSRC_DEF        = 4;
  localparam int unsigned ACK_TIMEOUT_DEF = 15;
  localparam int unsigned ESTAT_W         = 4;
  localparam int unsigned CNT_W           = 4;
  localparam int unsigned IDX_W           = 4;

  localparam logic [ESTAT_W-1:0] ESTAT_NONE = ESTAT_W'(0);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PENDING = 2'd1,
    ST_HANDLER = 2'd2,
    ST_RETURN  = 2'd3
  } exc_state_e;

  // Cause code for a source index: index+1, leaving 0 to mean "none".
  function automatic logic [ESTAT_W-1:0] estat_code(input logic [IDX_W-1:0] idx);
    return ESTAT_W'(idx) + ESTAT_W'(1);
  endfunction

endpackage

// File: rtl/exc_ctrl_prio_enc.sv
// Lowest-index-first priority encoder.
// Ports:
//   i_req   : N-bit request vector (any number of bits may be set)
//   o_idx   : index of the lowest set bit (0 when none set)
//   o_valid : 1 when any request bit is set
module prio_enc
  import exc_pkg::*;
#(
  parameter int unsigned N = NSRC_DEF
) (
  input  logic [N-1:0]     i_req,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_valid
);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    o_idx   = '0;
    o_valid = 1'b0;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (i_req[i]) begin
        o_idx   = IDX_W'(i);
        o_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/exc_ctrl.sv
// Exception controller: collects exception request pulses, raises Exc
// for the highest-priority one, waits for the fetch to reach the vector
// (ExcAck), tracks handler execution until ERET and flushes the pipeline
// on entry and on return.
// Ports:
//   clk, reset   : rising-edge clock, synchronous active-high reset
//   exc_req      : NSRC one-cycle request pulses, bit 0 highest priority
//   ExcAck       : fetch address equals exception vector
//   ERet         : ERET in Execute
//   Exc          : exception request to the exception unit
//   EStatus      : captured cause code (index+1, 0 = none)
//   Flush        : one-cycle F/D/E flush
//   InHandler    : handler executing
//   exc_pending  : sticky pending request bits
//   exc_timeout  : sticky ExcAck timeout flag
module exc_ctrl
  import exc_pkg::*;
#(
  parameter int unsigned NSRC        = NSRC_DEF,
  parameter int unsigned ACK_TIMEOUT = ACK_TIMEOUT_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NSRC-1:0]    exc_req,
  input  logic               ExcAck,
  input  logic               ERet,
  output logic               Exc,
  output logic [ESTAT_W-1:0] EStatus,
  output logic               Flush,
  output logic               InHandler,
  output logic [NSRC-1:0]    exc_pending,
  output logic               exc_timeout
);

  exc_state_e         r_state;
  exc_state_e         w_next;
  logic [NSRC-1:0]    r_pending;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_timeout;
  logic [ESTAT_W-1:0] r_estatus;

  logic [NSRC-1:0]    w_cand;
  logic [IDX_W-1:0]   w_idx;
  logic               w_valid;
  logic               w_capture;
  logic               w_ack;
  logic [NSRC-1:0]    w_clr;
  logic [NSRC-1:0]    w_pend_next;

  assign w_cand = r_pending | exc_req;

  prio_enc #(.N(NSRC)) u_prio_enc (
    .i_req   (w_cand),
    .o_idx   (w_idx),
    .o_valid (w_valid)
  );

  assign w_capture = (r_state == ST_IDLE) && w_valid;
  assign w_ack     = (r_state == ST_PENDING) && ExcAck;
  assign w_clr     = w_capture ? (NSRC'(1) << w_idx) : '0;

  // The captured bit is consumed, unless it was already pending and a
  // fresh pulse arrives on it in the same cycle: that new request stays.
  assign w_pend_next = ((r_pending | exc_req) & ~w_clr)
                     | (w_clr & r_pending & exc_req);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:    if (w_valid) w_next = ST_PENDING;
      ST_PENDING: if (ExcAck)  w_next = ST_HANDLER;
      ST_HANDLER: if (ERet)    w_next = ST_RETURN;
      ST_RETURN:               w_next = ST_IDLE;
      default:                 w_next = ST_IDLE;
    endcase
  end

  // Output decode; Flush is the only output that also looks at inputs.
  always_comb begin
    Exc       = 1'b0;
    InHandler = 1'b0;
    Flush     = 1'b0;
    case (r_state)
      ST_PENDING: begin
        Exc   = 1'b1;
        Flush = ExcAck && !reset;
      end
      ST_HANDLER: InHandler = 1'b1;
      ST_RETURN: begin
        InHandler = 1'b1;
        Flush     = !reset;
      end
      default: ;
    endcase
  end

  // Pending bits and cause capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pending <= '0;
      r_estatus <= ESTAT_NONE;
    end else begin
      r_pending <= w_pend_next;
      if (w_capture) r_estatus <= estat_code(w_idx);
    end
  end

  // ExcAck wait counter, saturating at ACK_TIMEOUT, with sticky timeout.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt     <= '0;
      r_timeout <= 1'b0;
    end else if (w_ack) begin
      r_cnt <= '0;
    end else if (r_state == ST_PENDING) begin
      if (r_cnt < CNT_W'(ACK_TIMEOUT)) begin
        r_cnt <= r_cnt + CNT_W'(1);
        if (r_cnt + CNT_W'(1) == CNT_W'(ACK_TIMEOUT)) r_timeout <= 1'b1;
      end
    end
  end

  assign EStatus     = r_estatus;
  assign exc_pending = r_pending;
  assign exc_timeout = r_timeout;

endmodule

// File: tb/tb_exc_ctrl.sv
module tb_exc_ctrl;

  localparam int unsigned NSRC  = 4;
  localparam int unsigned ACK_T = 15;

  logic            clk = 1'b0;
  logic            reset;
  logic [NSRC-1:0] exc_req;
  logic            ExcAck;
  logic            ERet;
  logic            Exc;
  logic [3:0]      EStatus;
  logic            Flush;
  logic            InHandler;
  logic [NSRC-1:0] exc_pending;
  logic            exc_timeout;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  exc_ctrl #(.NSRC(NSRC), .ACK_TIMEOUT(ACK_T)) dut (
    .clk         (clk),
    .reset       (reset),
    .exc_req     (exc_req),
    .ExcAck      (ExcAck),
    .ERet        (ERet),
    .Exc         (Exc),
    .EStatus     (EStatus),
    .Flush       (Flush),
    .InHandler   (InHandler),
    .exc_pending (exc_pending),
    .exc_timeout (exc_timeout)
  );

  // Reference model: phase 0 idle, 1 waiting for ack, 2 in handler, 3 returning.
  int              m_phase;
  logic [NSRC-1:0] m_pend;
  int              m_estat;
  int              m_wait;
  logic            m_to;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    logic [NSRC-1:0] old_pend;
    int k;
    if (reset) begin
      m_phase = 0; m_pend = '0; m_estat = 0; m_wait = 0; m_to = 1'b0;
      return;
    end
    old_pend = m_pend;
    m_pend   = m_pend | exc_req;
    case (m_phase)
      0: begin
        k = -1;
        for (int i = 0; i < int'(NSRC); i++)
          if (k < 0 && (old_pend[i] || exc_req[i])) k = i;
        if (k >= 0) begin
          m_estat   = k + 1;
          m_pend[k] = old_pend[k] && exc_req[k];
          m_phase   = 1;
          m_wait    = 0;
        end
      end
      1: begin
        if (ExcAck) begin
          m_phase = 2;
          m_wait  = 0;
        end else if (m_wait < int'(ACK_T)) begin
          m_wait++;
          if (m_wait == int'(ACK_T)) m_to = 1'b1;
        end
      end
      2: if (ERet) m_phase = 3;
      default: m_phase = 0;
    endcase
  endtask

  // One clock cycle: drive, compare every output mid-cycle, advance the model.
  task automatic cyc(input logic [NSRC-1:0] req, input logic ack, input logic eret,
                     input logic rst);
    exc_req = req; ExcAck = ack; ERet = eret; reset = rst;
    @(negedge clk);
    chk("exc",     32'(Exc),         32'(m_phase == 1));
    chk("inhand",  32'(InHandler),   32'(m_phase == 2 || m_phase == 3));
    chk("flush",   32'(Flush),       32'(!rst && ((m_phase == 1 && ack) || m_phase == 3)));
    chk("estat",   32'(EStatus),     32'(m_estat));
    chk("pending", 32'(exc_pending), 32'(m_pend));
    chk("timeout", 32'(exc_timeout), 32'(m_to));
    @(posedge clk);
    model_step();
    #1;
  endtask

  initial begin
    m_phase = 0; m_pend = '0; m_estat = 0; m_wait = 0; m_to = 1'b0;
    exc_req = '0; ExcAck = 1'b0; ERet = 1'b0; reset = 1'b1;
    @(posedge clk); #1;
    cyc('0, 0, 0, 1);
    chk("rst_exc",     32'(Exc), 0);
    chk("rst_estat",   32'(EStatus), 0);
    chk("rst_pending", 32'(exc_pending), 0);
    cyc('0, 0, 0, 0);
    cyc('0, 0, 0, 0);

    // Single request: one-cycle latency, ack flushes, handler follows.
    cyc(4'b0100, 0, 0, 0);
    chk("single_exc",   32'(Exc), 1);
    chk("single_estat", 32'(EStatus), 3);
    cyc('0, 0, 0, 0);
    cyc('0, 0, 0, 0);
    cyc('0, 1, 0, 0);
    chk("single_inh", 32'(InHandler), 1);
    chk("single_exc0", 32'(Exc), 0);

    // Return, then two simultaneous requests.
    cyc('0, 0, 1, 0);
    cyc('0, 0, 0, 0);
    chk("ret_idle_exc", 32'(Exc), 0);
    chk("ret_estat_hold", 32'(EStatus), 3);
    cyc(4'b1010, 0, 0, 0);
    chk("simul_estat", 32'(EStatus), 2);
    chk("simul_pend",  32'(exc_pending), 32'(4'b1000));
    cyc('0, 1, 0, 0);
    cyc('0, 0, 1, 0);
    cyc('0, 0, 0, 0);
    cyc('0, 0, 0, 0);
    chk("reraise_exc",   32'(Exc), 1);
    chk("reraise_estat", 32'(EStatus), 4);

    // Masking inside the handler, re-raise three cycles after ERET.
    cyc('0, 1, 0, 0);
    cyc(4'b0001, 0, 0, 0);
    chk("mask_exc",  32'(Exc), 0);
    chk("mask_pend", 32'(exc_pending), 32'(4'b0001));
    cyc('0, 0, 1, 0);
    chk("mask_ret_inh", 32'(InHandler), 1);
    cyc('0, 0, 0, 0);
    chk("mask_idle_exc", 32'(Exc), 0);
    cyc('0, 0, 0, 0);
    chk("mask_exc1",  32'(Exc), 1);
    chk("mask_estat", 32'(EStatus), 1);

    // Timeout: already one PENDING cycle due; flag appears after 15.
    for (int i = 0; i < 14; i++) cyc('0, 0, 0, 0);
    chk("to_before", 32'(exc_timeout), 0);
    cyc('0, 0, 0, 0);
    chk("to_set", 32'(exc_timeout), 1);
    cyc('0, 0, 0, 0);
    chk("to_exc", 32'(Exc), 1);
    cyc('0, 1, 0, 0);
    chk("to_inh",    32'(InHandler), 1);
    chk("to_sticky", 32'(exc_timeout), 1);

    // Reset mid-handler with pending bits; coincident requests are dropped.
    cyc(4'b0110, 0, 0, 0);
    chk("mid_pend", 32'(exc_pending), 32'(4'b0110));
    cyc(4'b1111, 0, 0, 1);
    chk("mid_rst_inh",   32'(InHandler), 0);
    chk("mid_rst_pend",  32'(exc_pending), 0);
    chk("mid_rst_estat", 32'(EStatus), 0);
    chk("mid_rst_to",    32'(exc_timeout), 0);

    // Spurious ack/eret in IDLE.
    cyc('0, 1, 0, 0);
    cyc('0, 0, 1, 0);
    cyc('0, 1, 1, 0);
    chk("spur_exc", 32'(Exc), 0);
    chk("spur_inh", 32'(InHandler), 0);

    // Randomized traffic against the model.
    for (int n = 0; n < 600; n++) begin
      logic [NSRC-1:0] r;
      for (int b = 0; b < int'(NSRC); b++) r[b] = ($urandom_range(0, 9) == 0);
      cyc(r, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
          $urandom_range(0, 79) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
